half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 23 ++
 rtl/half_adder_cell.sv | 13 +
 rtl/half_adder.sv | 60 ++++++
 tb/tb_half_adder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared types and helpers for the lane-wise half adder.
// Used by the RTL and by the testbench scoreboard.
package half_adder_pkg;

  localparam int unsigned HA_WIDTH_DEFAULT = 1;
  localparam int unsigned HA_MAX_W = 32;

  typedef struct packed {
    logic [HA_MAX_W-1:0] c;
    logic [HA_MAX_W-1:0] s;
  } ha_res_t;

  function automatic ha_res_t ha_eval(
    input logic [HA_MAX_W-1:0] a,
    input logic [HA_MAX_W-1:0] b
  );
    ha_res_t r;
    r.c = a & b;
    r.s = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit half adder lane.
// Purely combinational carry and sum.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic c,
  output logic s
);

  assign c = a & b;
  assign s = a ^ b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with an optional
// output register stage and a valid qualifier.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH      = HA_WIDTH_DEFAULT,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] s_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .c (c_d[i]),
      .s (s_d[i])
    );
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] s_q;
    logic             v_q;

    // c/s only load on valid so idle inputs never disturb them
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q <= '0;
        s_q <= '0;
        v_q <= 1'b0;
      end else begin
        v_q <= in_valid;
        if (in_valid) begin
          c_q <= c_d;
          s_q <= s_d;
        end
      end
    end

    assign c         = c_q;
    assign s         = s_q;
    assign out_valid = v_q;
  end else begin : g_comb
    assign c         = c_d;
    assign s         = s_d;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_half_adder.sv
// Randomized self-checking bench for half_adder.
// Covers registered W=1, W=4 and combinational W=1.
module tb_half_adder;
  import half_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       a1, b1, v1, ov1, c1, s1;
  logic [3:0] a4, b4, c4, s4;
  logic       v4, ov4;
  logic       a0, b0, v0, ov0, c0, s0;

  int n_chk = 0;
  int n_bad = 0;

  logic       e1_c, e1_s, e1_v;
  logic [3:0] e4_c, e4_s;
  logic       e4_v;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .a(a1), .b(b1),
    .out_valid(ov1), .c(c1), .s(s1)
  );

  half_adder #(.WIDTH(4), .REGISTERED(1'b1)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4),
    .a(a4), .b(b4),
    .out_valid(ov4), .c(c4), .s(s4)
  );

  half_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0),
    .a(a0), .b(b0),
    .out_valid(ov0), .c(c0), .s(s0)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane sum as plain arithmetic: a+b = 2*carry + sum
  function automatic logic [7:0] ref4(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] rc, rs;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = int'(a[i]) + int'(b[i]);
      rc[i] = (t / 2) != 0;
      rs[i] = (t % 2) != 0;
    end
    return {rc, rs};
  endfunction

  task automatic chk_all();
    chk("r1_v", 32'(ov1), 32'(e1_v));
    chk("r1_c", 32'(c1), 32'(e1_c));
    chk("r1_s", 32'(s1), 32'(e1_s));
    chk("r4_v", 32'(ov4), 32'(e4_v));
    chk("r4_c", 32'(c4), 32'(e4_c));
    chk("r4_s", 32'(s4), 32'(e4_s));
  endtask

  task automatic cyc(
    input logic       ia1, ib1, iv1,
    input logic [3:0] ia4, ib4,
    input logic       iv4
  );
    logic [7:0] r;
    @(negedge clk);
    a1 = ia1; b1 = ib1; v1 = iv1;
    a4 = ia4; b4 = ib4; v4 = iv4;
    @(posedge clk);
    e1_v = iv1;
    if (iv1) begin
      r = ref4({3'b0, ia1}, {3'b0, ib1});
      e1_c = r[4];
      e1_s = r[0];
    end
    e4_v = iv4;
    if (iv4) begin
      r = ref4(ia4, ib4);
      {e4_c, e4_s} = r;
      chk("pkg_c", ha_eval(32'(ia4), 32'(ib4)).c, 32'(r[7:4]));
      chk("pkg_s", ha_eval(32'(ia4), 32'(ib4)).s, 32'(r[3:0]));
    end
    #1;
    chk_all();
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a4 = 4'h5; b4 = 4'h3; v4 = 1'b1;
    a0 = 1'b0; b0 = 1'b0; v0 = 1'b0;
    e1_c = 0; e1_s = 0; e1_v = 0;
    e4_c = '0; e4_s = '0; e4_v = 0;

    // held in reset with valid inputs driven
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    e1_c = 1; e1_s = 0; e1_v = 1;
    {e4_c, e4_s} = ref4(4'h5, 4'h3);
    e4_v = 1;
    #1;
    chk_all();

    // truth table plus multi-lane directed vectors
    cyc(0, 0, 1, 4'b1010, 4'b0110, 1);
    cyc(0, 1, 1, 4'hF, 4'hF, 1);
    cyc(1, 0, 1, 4'h0, 4'h0, 1);
    cyc(1, 1, 1, 4'hF, 4'h0, 1);
    chk("dir_c4", 32'(c4), 32'h0);
    chk("dir_s4", 32'(s4), 32'hF);

    // hold with idle and unknown inputs
    cyc(1, 1, 1, 4'b1010, 4'b0110, 1);
    chk("ml_c", 32'(c4), 32'h2);
    chk("ml_s", 32'(s4), 32'hC);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 4'bxxxx, 4'bxxxx, 0);
    chk("hold_c1", 32'(c1), 32'h1);
    chk("hold_s1", 32'(s1), 32'h0);

    // random stream
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom_range(3) != 0),
          4'($urandom), 4'($urandom), 1'($urandom_range(3) != 0));

    // async reset between edges
    cyc(1, 1, 1, 4'hF, 4'hF, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e1_c = 0; e1_s = 0; e1_v = 0;
    e4_c = '0; e4_s = '0; e4_v = 0;
    chk_all();
    @(negedge clk);
    v1 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;
    cyc(1, 1, 0, 4'hF, 4'hF, 0);
    cyc(1, 0, 1, 4'b1100, 4'b1010, 1);
    for (int i = 0; i < 10; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom),
          4'($urandom), 4'($urandom), 1'($urandom));

    // combinational instance ignores reset and clock
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] r;
      #10;
      a0 = i[1]; b0 = i[0]; v0 = i[0];
      #1;
      r = ref4({3'b0, a0}, {3'b0, b0});
      chk("cb_c", 32'(c0), 32'(r[4]));
      chk("cb_s", 32'(s0), 32'(r[0]));
      chk("cb_v", 32'(ov0), 32'(v0));
    end
    v0 = 1'b0;
    a0 = 1'b1; b0 = 1'b1;
    #1;
    chk("cb_nv_c", 32'(c0), 32'h1);
    chk("cb_nv_v", 32'(ov0), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
